// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
package seg_scan_pkg;

  typedef enum logic {
    GAP = 1'b0,
    ON  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low segment patterns, bit order gfedcba (seg[6] = g).
  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/seg_scan_ctrl_seg7_digit_lut.sv
// BCD digit to active-low 7-segment pattern; values above 9 are blanked.
module seg7_digit_lut
  import seg_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (digit < 4'd10) seg = SEG_DIGITS[digit];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans four BCD digits across a shared active-low 7-segment bus with a blanking gap per slot.
// Optional build macro: LEAD_ZERO_BLANK_EN (blank leading zero digits of the displayed value).
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GAP_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr,
  input  logic [15:0] wr_data,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_start
);
  import seg_scan_pkg::*;

  localparam int unsigned   CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);

  scan_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          dark, dark_nxt;
  logic          boundary;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic [15:0]   shadow, active;
  logic          pending;
  logic [3:0]    digit, lut_in;
  logic [6:0]    digit_seg;

  assign digit = active[{idx, 2'b00} +: 4];

`ifdef LEAD_ZERO_BLANK_EN
  logic [3:1] lead_zero;
  assign lead_zero[3] = (active[15:12] == 4'd0);
  assign lead_zero[2] = lead_zero[3] && (active[11:8] == 4'd0);
  assign lead_zero[1] = lead_zero[2] && (active[7:4] == 4'd0);
  // A blanked digit is steered to an out-of-range code so the LUT emits SEG_OFF.
  assign lut_in = (idx != 2'd0 && lead_zero[idx]) ? 4'hF : digit;
`else
  assign lut_in = digit;
`endif

  seg7_digit_lut u_lut (
    .digit (lut_in),
    .seg   (digit_seg)
  );

  // dark marks "not scanning"; the first enabled edge out of it is a frame boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    dark_nxt  = dark;
    boundary  = 1'b0;
    if (!en) begin
      state_nxt = GAP;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      dark_nxt  = 1'b1;
    end else if (dark) begin
      state_nxt = GAP;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      dark_nxt  = 1'b0;
      boundary  = 1'b1;
    end else begin
      unique case (state)
        GAP: if (cnt == GAP_LAST) state_nxt = ON;
        ON: if (cnt == SLOT_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          boundary  = (idx == 2'd3);
        end
        default: state_nxt = GAP;
      endcase
    end

    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    if (state_nxt == ON) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = digit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GAP;
      cnt         <= '0;
      idx         <= '0;
      dark        <= 1'b1;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      dark        <= dark_nxt;
      seg         <= seg_nxt;
      an          <= an_nxt;
      frame_start <= boundary;
      if (boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      // A write on the boundary edge lands after the apply, so it waits one frame.
      if (wr) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GAP   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst, en, wr;
  logic [15:0] wr_data;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  seg_scan_ctrl #(.REFRESH_DIV(DIV), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr          (wr),
    .wr_data     (wr_data),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Model: pos = cycles since last frame boundary, -1 while dark.
  int          pos       = -1;
  logic [15:0] m_shadow  = '0;
  logic [15:0] m_active  = '0;
  bit          m_pending = 0;
  logic        exp_fs    = 1'b0;

  always @(posedge clk) begin
    bit b;
    b = 0;
    if (rst) begin
      pos = -1; m_shadow = '0; m_active = '0; m_pending = 0; exp_fs = 1'b0;
    end else begin
      if (!en) pos = -1;
      else if (pos < 0) begin pos = 0; b = 1; end
      else begin pos = (pos + 1) % FRAME; b = (pos == 0); end
      if (b && m_pending) begin m_active = m_shadow; m_pending = 0; end
      if (wr) begin m_shadow = wr_data; m_pending = 1; end
      exp_fs = b;
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] digit_pat(input int slot);
    logic [3:0] d;
    d = m_active[slot*4 +: 4];
`ifdef LEAD_ZERO_BLANK_EN
    if (slot > 0 && (m_active >> (slot * 4)) == 16'd0) return 7'b1111111;
`endif
    return decode(d);
  endfunction

  // Expected {an, seg} for the current model position.
  function automatic logic [10:0] expect_out();
    int slot, w;
    logic [3:0] a;
    if (pos < 0) return {4'hF, 7'h7F};
    slot = pos / DIV;
    w    = pos % DIV;
    if (w < GAP) return {4'hF, 7'h7F};
    a = 4'hF;
    a[slot] = 1'b0;
    return {a, digit_pat(slot)};
  endfunction

  task automatic tick(input logic r, input logic e, input logic w, input logic [15:0] d);
    rst = r; en = e; wr = w; wr_data = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 16'(($urandom)));
    checks++;
    if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got an=%b seg=%b fs=%b want 1111 1111111 0", an, seg, frame_start);
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    exp = expect_out();
    checks++;
    if (frame_start !== 1'b1 || {an, seg} !== exp) begin
      failures++;
      $display("FAIL reset_release: got an=%b seg=%b fs=%b want an=%b seg=%b fs=1", an, seg, frame_start, exp[10:7], exp[6:0]);
    end
  endtask

  task automatic test_scan();
    logic [10:0] exp;
    int on0, fs_cnt;
    on0 = 0; fs_cnt = 0;
    tick(1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 16'h1234);
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      exp = expect_out();
      checks++;
      if ({an, seg, frame_start} !== {exp, exp_fs}) begin
        failures++;
        $display("FAIL scan c=%0d: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", c, an, seg, frame_start, exp[10:7], exp[6:0], exp_fs);
      end
      if (c >= FRAME - 1 && an == 4'b1110) begin
        on0++;
        checks++;
        if (seg !== 7'b0011001) begin
          failures++;
          $display("FAIL scan_digit0: got seg=%b want 0011001", seg);
        end
      end
      if (c >= FRAME - 1 && an == 4'b0111) begin
        checks++;
        if (seg !== 7'b1111001) begin
          failures++;
          $display("FAIL scan_digit3: got seg=%b want 1111001", seg);
        end
      end
      fs_cnt += int'(frame_start);
    end
    checks++;
    if (on0 != DIV - GAP) begin
      failures++;
      $display("FAIL scan_on_len: got %0d cycles want %0d", on0, DIV - GAP);
    end
    checks++;
    if (fs_cnt != 2) begin
      failures++;
      $display("FAIL scan_fs_count: got %0d want 2", fs_cnt);
    end
  endtask

  task automatic test_last_write_wins();
    logic [10:0] exp;
    int fs_cnt;
    fs_cnt = 0;
    tick(1'b0, 1'b1, 1'b1, 16'h1111);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 16'h2222);
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      exp = expect_out();
      checks++;
      if ({an, seg, frame_start} !== {exp, exp_fs}) begin
        failures++;
        $display("FAIL last_write c=%0d: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", c, an, seg, frame_start, exp[10:7], exp[6:0], exp_fs);
      end
      fs_cnt += int'(frame_start);
    end
    checks++;
    if (fs_cnt != 2) begin
      failures++;
      $display("FAIL last_write_fs_count: got %0d want 2", fs_cnt);
    end
  endtask

  task automatic test_boundary_write();
    logic [10:0] exp;
    for (int i = 0; i < 2 * FRAME && pos != 5; i++) tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 16'h5678);
    for (int i = 0; i < 2 * FRAME && pos != FRAME - 1; i++) tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (pos != FRAME - 1) begin
      failures++;
      $display("FAIL boundary_wait: got pos=%0d want %0d", pos, FRAME - 1);
    end
    tick(1'b0, 1'b1, 1'b1, 16'h9999);
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      if (c == GAP) begin
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0000000) begin
          failures++;
          $display("FAIL boundary_old_shadow: got an=%b seg=%b want 1110 0000000", an, seg);
        end
      end
      if (c == FRAME + GAP) begin
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0010000) begin
          failures++;
          $display("FAIL boundary_new_shadow: got an=%b seg=%b want 1110 0010000", an, seg);
        end
      end
      exp = expect_out();
      checks++;
      if ({an, seg, frame_start} !== {exp, exp_fs}) begin
        failures++;
        $display("FAIL boundary c=%0d: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", c, an, seg, frame_start, exp[10:7], exp[6:0], exp_fs);
      end
      tick(1'b0, 1'b1, 1'b0, '0);
    end
  endtask

  task automatic test_blank_digit();
    logic [10:0] exp;
    logic [15:0] d;
    for (int k = 0; k < 4; k++) begin
      d = 16'($urandom);
      d[k*4 +: 4] = 4'hA;
      tick(1'b0, 1'b1, 1'b1, d);
      for (int c = 0; c < 2 * FRAME; c++) begin
        tick(1'b0, 1'b1, 1'b0, '0);
        exp = expect_out();
        checks++;
        if ({an, seg, frame_start} !== {exp, exp_fs}) begin
          failures++;
          $display("FAIL blank_digit k=%0d c=%0d: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", k, c, an, seg, frame_start, exp[10:7], exp[6:0], exp_fs);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    logic [10:0] exp;
    for (int i = 0; i < 2 * FRAME && pos != 2 * DIV + 3; i++) tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (an !== 4'b1011) begin
      failures++;
      $display("FAIL en_drop_pre: got an=%b want 1011", an);
    end
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b0}) begin
      failures++;
      $display("FAIL en_drop_dark: got an=%b seg=%b fs=%b want 1111 1111111 0", an, seg, frame_start);
    end
    tick(1'b0, 1'b0, 1'b1, 16'h4321);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL en_rise: got an=%b seg=%b fs=%b want 1111 1111111 1", an, seg, frame_start);
    end
    for (int c = 0; c < FRAME + 4; c++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      exp = expect_out();
      checks++;
      if ({an, seg, frame_start} !== {exp, exp_fs}) begin
        failures++;
        $display("FAIL en_resume c=%0d: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", c, an, seg, frame_start, exp[10:7], exp[6:0], exp_fs);
      end
    end
  endtask

  task automatic test_lead_zero();
    logic [10:0] exp;
    logic [15:0] vals [3];
    vals = '{16'h0007, 16'h0000, 16'h0040};
    foreach (vals[k]) begin
      tick(1'b0, 1'b1, 1'b1, vals[k]);
      for (int c = 0; c < 2 * FRAME; c++) begin
        tick(1'b0, 1'b1, 1'b0, '0);
        exp = expect_out();
        checks++;
        if ({an, seg, frame_start} !== {exp, exp_fs}) begin
          failures++;
          $display("FAIL lead_zero v=%h c=%0d: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", vals[k], c, an, seg, frame_start, exp[10:7], exp[6:0], exp_fs);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    logic r, e, w;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 59) != 0) || (c % 400 > 380 ? 1'b0 : 1'b1) == 1'b0 ? 1'b0 : 1'b1;
      if (c % 400 > 390) e = 1'b0;
      w = ($urandom_range(0, 15) == 0);
      tick(r, e, w, 16'($urandom));
      exp = expect_out();
      checks++;
      if ({an, seg, frame_start} !== {exp, exp_fs}) begin
        failures++;
        $display("FAIL random c=%0d: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", c, an, seg, frame_start, exp[10:7], exp[6:0], exp_fs);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; wr_data = '0;
    @(negedge clk);
    test_reset();
    test_scan();
    test_last_write_wins();
    test_boundary_write();
    test_blank_digit();
    test_en_drop();
    test_lead_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
